// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared constants, state type and slice helper for arbitro_rr_8canais
package arbitro_pkg;

  localparam int CANAIS  = 8;
  localparam int LARGURA = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    OCIOSO    = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

  // Low bit of channel 'canal' inside the packed entradas bus
  function automatic int indice_fatia(input logic [SEL_W-1:0] canal);
    return LARGURA * int'(canal);
  endfunction

endpackage

// File: rtl/rr_prioridade.sv
// rtl/rr_prioridade.sv - combinational rotating-priority picker, search starts at ponteiro
module rr_prioridade
  import arbitro_pkg::*;
(
  input  logic [CANAIS-1:0] req_i,
  input  logic [SEL_W-1:0]  ponteiro_i,
  output logic [CANAIS-1:0] concessao_o,
  output logic [SEL_W-1:0]  indice_o,
  output logic              algum_o
);

  logic [SEL_W-1:0] candidato;
  logic             achado;

  // Walk ponteiro, ponteiro+1, ... (3-bit wrap) and keep the first requester seen
  always_comb begin
    concessao_o = '0;
    indice_o    = '0;
    candidato   = '0;
    achado      = 1'b0;
    for (int k = 0; k < CANAIS; k++) begin
      candidato = ponteiro_i + SEL_W'(k);
      if (!achado && req_i[candidato]) begin
        achado                 = 1'b1;
        indice_o               = candidato;
        concessao_o[candidato] = 1'b1;
      end
    end
  end

  assign algum_o = |req_i;

endmodule

// File: rtl/arbitro_rr_8canais.sv
// rtl/arbitro_rr_8canais.sv - 8-channel round-robin arbiter with registered valid/ready output (optional ARBITRO_CONTADORES_EN grant counters)
module arbitro_rr_8canais
  import arbitro_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CANAIS-1:0]         req,
  input  logic [CANAIS*LARGURA-1:0] entradas,
  output logic [CANAIS-1:0]         ack,
  output logic [SEL_W-1:0]          seletor,
  output logic [LARGURA-1:0]        saida,
  output logic                      saida_valida,
`ifdef ARBITRO_CONTADORES_EN
  input  logic [SEL_W-1:0]          cont_sel,
  output logic [15:0]               cont_valor,
`endif
  input  logic                      saida_pronta
);

  estado_t             estado_q;
  logic [SEL_W-1:0]    ponteiro_q;
  logic [SEL_W-1:0]    seletor_q;
  logic [LARGURA-1:0]  saida_q;
  logic                valida_q;

  logic [CANAIS-1:0]   concessao;
  logic [SEL_W-1:0]    indice;
  logic                algum;
  logic                concede;

  rr_prioridade u_prioridade (
    .req_i       (req),
    .ponteiro_i  (ponteiro_q),
    .concessao_o (concessao),
    .indice_o    (indice),
    .algum_o     (algum)
  );

  // A grant is taken when the output slot is free or being consumed this cycle; never during reset
  always_comb begin
    concede = rst_n && algum && ((estado_q == OCIOSO) || saida_pronta);
    ack     = concede ? concessao : '0;
  end

  // Arbiter FSM: capture the granted word, advance the pointer past the winner, drop valid once drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q   <= OCIOSO;
      ponteiro_q <= '0;
      seletor_q  <= '0;
      saida_q    <= '0;
      valida_q   <= 1'b0;
    end else begin
      if (concede) begin
        estado_q   <= CONCEDIDO;
        ponteiro_q <= indice + SEL_W'(1);
        seletor_q  <= indice;
        saida_q    <= entradas[indice_fatia(indice) +: LARGURA];
        valida_q   <= 1'b1;
      end else if ((estado_q == CONCEDIDO) && saida_pronta) begin
        estado_q   <= OCIOSO;
        valida_q   <= 1'b0;
      end
    end
  end

  assign seletor      = seletor_q;
  assign saida        = saida_q;
  assign saida_valida = valida_q;

`ifdef ARBITRO_CONTADORES_EN
  logic [15:0] contador_q [CANAIS];

  // Per-channel saturating grant counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CANAIS; i++) contador_q[i] <= '0;
    end else begin
      for (int i = 0; i < CANAIS; i++) begin
        if (ack[i] && (contador_q[i] != 16'hFFFF)) contador_q[i] <= contador_q[i] + 16'd1;
      end
    end
  end

  assign cont_valor = contador_q[cont_sel];
`endif

endmodule

// File: tb/tb_arbitro_rr_8canais.sv
// tb/tb_arbitro_rr_8canais.sv - randomized self-checking bench against a round-robin reference model
module tb_arbitro_rr_8canais;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req;
  logic [63:0] entradas;
  logic [7:0]  ack;
  logic [2:0]  seletor;
  logic [7:0]  saida;
  logic        saida_valida;
  logic        saida_pronta;
`ifdef ARBITRO_CONTADORES_EN
  logic [2:0]  cont_sel;
  logic [15:0] cont_valor;
`endif

  logic [7:0]  dado [8];
  bit          pend [8];

  int n_comp = 0;
  int n_erro = 0;

  // reference model state
  bit         m_valid;
  logic [7:0] m_saida;
  int         m_sel;
  int         m_ptr;
  int         espera [8];
  int         espera_max;
  int         m_cont [8];

  always #5 clk = ~clk;

  always_comb begin
    entradas = '0;
    for (int i = 0; i < 8; i++) entradas[i*8 +: 8] = dado[i];
  end

  arbitro_rr_8canais dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .entradas     (entradas),
    .ack          (ack),
    .seletor      (seletor),
    .saida        (saida),
    .saida_valida (saida_valida),
`ifdef ARBITRO_CONTADORES_EN
    .cont_sel     (cont_sel),
    .cont_valor   (cont_valor),
`endif
    .saida_pronta (saida_pronta)
  );

  task automatic confere(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
    n_comp++;
    if (obtido !== esperado) begin
      n_erro++;
      $display("FAIL %s: obtido=%h esperado=%h (t=%0t)", tag, obtido, esperado, $time);
    end
  endtask

  function automatic int escolhe(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic int vencedor();
    if (!rst_n) return -1;
    if (m_valid && !saida_pronta) return -1;
    return escolhe(req, m_ptr);
  endfunction

  task automatic modelo_reset();
    m_valid = 0; m_saida = 8'h00; m_sel = 0; m_ptr = 0; espera_max = 0;
    for (int i = 0; i < 8; i++) begin
      espera[i] = 0; m_cont[i] = 0; pend[i] = 0;
    end
  endtask

  // Check all outputs against the model, clock once, advance the model
  task automatic passo(output int c);
    logic [7:0] ack_esp;
    #1;
    c = vencedor();
    ack_esp = (c >= 0) ? 8'(1 << c) : 8'h00;
    confere("ack", 32'(ack), 32'(ack_esp));
    confere("saida_valida", 32'(saida_valida), 32'(m_valid));
    confere("saida", 32'(saida), 32'(m_saida));
    confere("seletor", 32'(seletor), 32'(m_sel));
`ifdef ARBITRO_CONTADORES_EN
    confere("cont_valor", 32'(cont_valor), 32'(m_cont[cont_sel]));
`endif
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      if (!req[i] || i == c) espera[i] = 0;
      else if (c >= 0) espera[i]++;
      if (espera[i] > espera_max) espera_max = espera[i];
    end
    if (c >= 0) begin
      m_saida = dado[c]; m_sel = c; m_ptr = (c + 1) % 8; m_valid = 1;
      if (m_cont[c] < 65535) m_cont[c]++;
    end else if (m_valid && saida_pronta) begin
      m_valid = 0;
    end
    #1;
  endtask

  initial begin
    int c;
    rst_n = 1'b0; req = 8'hFF; saida_pronta = 1'b1;
`ifdef ARBITRO_CONTADORES_EN
    cont_sel = 3'd0;
`endif
    for (int i = 0; i < 8; i++) dado[i] = 8'h10 + 8'(i);
    modelo_reset();

    // reset state
    #3;
    confere("rst_saida", 32'(saida), 32'h00);
    confere("rst_seletor", 32'(seletor), 32'h0);
    confere("rst_valida", 32'(saida_valida), 32'h0);
    confere("rst_ack", 32'(ack), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 confere("rst_ack_apos", 32'(ack), 32'h01);

    // rotation, one word per cycle
    for (int i = 0; i < 9; i++) begin
      passo(c);
      confere("rot_seletor", 32'(seletor), 32'(i % 8));
      confere("rot_saida", 32'(saida), 32'(8'h10 + 8'(i % 8)));
    end

    // backpressure
    req = 8'h00;
    passo(c); passo(c);
    req = 8'h04; dado[2] = 8'hA5; saida_pronta = 1'b0;
    passo(c);
    for (int i = 0; i < 5; i++) begin
      confere("bp_saida", 32'(saida), 32'hA5);
      confere("bp_valida", 32'(saida_valida), 32'h1);
      confere("bp_ack", 32'(ack), 32'h00);
      passo(c);
    end
    saida_pronta = 1'b1; req = 8'h00;
    passo(c);
    confere("bp_fim_valida", 32'(saida_valida), 32'h0);

    // wrap and skip
    req = 8'h40;
    passo(c);
    req = 8'h41;
    #1 confere("wrap_ack", 32'(ack), 32'h01);
    passo(c);
    confere("wrap_sel0", 32'(seletor), 32'h0);
    req = 8'h40;
    passo(c);
    confere("wrap_sel6", 32'(seletor), 32'h6);
    req = 8'h00;
    passo(c);

    // reset mid-transfer
    req = 8'h08; dado[3] = 8'h3C; saida_pronta = 1'b0;
    passo(c);
    confere("mid_valida_antes", 32'(saida_valida), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    confere("mid_valida", 32'(saida_valida), 32'h0);
    confere("mid_ack", 32'(ack), 32'h00);
    modelo_reset();
    #1 rst_n = 1'b1; req = 8'hFF;
    #1 confere("mid_ack_apos", 32'(ack), 32'h01);
    passo(c);
    confere("mid_sel", 32'(seletor), 32'h0);

    // randomized traffic under the requester contract
    for (int i = 0; i < 8; i++) pend[i] = 0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 8; i++) req[i] = pend[i];
      saida_pronta = ($urandom_range(3) != 0);
`ifdef ARBITRO_CONTADORES_EN
      cont_sel = 3'($urandom_range(7));
`endif
      passo(c);
      for (int i = 0; i < 8; i++) begin
        if (!pend[i] || i == c) begin
          pend[i] = ($urandom_range(2) == 0) || (pend[i] && $urandom_range(1) == 0);
          if (pend[i]) dado[i] = 8'($urandom);
        end else if ($urandom_range(15) == 0) begin
          pend[i] = 0;
        end
      end
    end
    confere("justica", 32'(espera_max <= 7), 32'h1);

`ifdef ARBITRO_CONTADORES_EN
    // counter saturation
    @(negedge clk);
    rst_n = 1'b0; modelo_reset();
    #1 rst_n = 1'b1;
    req = 8'h08; saida_pronta = 1'b1; cont_sel = 3'd3;
    for (int n = 0; n < 70000; n++) passo(c);
    req = 8'h00;
    #1 confere("cont_sat", 32'(cont_valor), 32'hFFFF);
    cont_sel = 3'd2;
    #1 confere("cont_zero", 32'(cont_valor), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_erro);
    $finish;
  end

endmodule

// File: doc/arbitro_rr_8canais.md
Name: arbitro_rr_8canais

Overview:
- Round-robin arbiter/scheduler that shares the 8-channel, 8-bit multiplexer datapath between 8 independent requesters.
- Picks one requesting channel and drives the mux selector.
- Registers the selected 8-bit word and presents it downstream with a valid/ready handshake.
- Sits between the per-channel producers and the single shared consumer of the muxed byte.

Parameters:
- LARGURA, 8, data width per channel in bits.
- CANAIS, 8, number of channels (fixed at 8; selector width SEL_W = 3).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  CANAIS  per-channel request; bit i set = channel i has a word ready.
- entradas  input  CANAIS*LARGURA  packed channel data; channel i occupies bits [i*LARGURA +: LARGURA].
- ack  output  CANAIS  one-hot grant/consume strobe; ack[i]=1 means entradas for channel i is captured at this edge.
- seletor  output  3  index of the channel currently held in saida.
- saida  output  LARGURA  registered selected word.
- saida_valida  output  1  saida holds an unconsumed word.
- saida_pronta  input  1  downstream ready.

Behaviour:
- Reset (rst_n=0, asynchronous): saida=0, seletor=0, saida_valida=0, ponteiro=0, state=OCIOSO. ack is forced to 0 while rst_n=0.
- State OCIOSO:
  - saida_valida=0.
  - If req != 0, ack selects the first set req bit, searching ponteiro, ponteiro+1, ... mod 8.
  - At the edge: saida <= entradas[chosen], seletor <= chosen, ponteiro <= chosen+1 (mod 8, wraps 7->0), state <= CONCEDIDO.
- State CONCEDIDO:
  - saida_valida=1; saida and seletor hold stable while saida_pronta=0.
  - ack=0 while saida_pronta=0.
  - When saida_pronta=1 and req != 0: a new grant is taken in the same cycle (back-to-back, one word per cycle). State stays CONCEDIDO.
  - When saida_pronta=1 and req == 0: state <= OCIOSO.
- Latency: a request arriving in OCIOSO produces saida_valida=1 one cycle later.
- ack is combinational from state, saida_pronta, req and ponteiro; it is at most one-hot.
- Requester contract: hold req[i] and its data until ack[i]=1; req may drop or stay high after ack. A req that drops without ack is simply not served.
- Fairness: a continuously requesting channel waits at most 7 grants.
- Single requester: it may be granted on every consecutive cycle; ponteiro still advances.
- Reset mid-transfer: the held word is discarded and saida_valida drops immediately.

Optional Feature:
- Macro ARBITRO_CONTADORES_EN.
- When defined:
  - Adds input cont_sel (3 bits) and output cont_valor (16 bits).
  - One 16-bit saturating grant counter per channel, incremented on each ack[i]. It holds at 16'hFFFF.
  - Counters reset to 0.
  - cont_valor = counter[cont_sel], combinational.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package arbitro_pkg holds:
  - CANAIS=8, LARGURA=8, SEL_W=3.
  - Enum estado_t {OCIOSO, CONCEDIDO}.
  - Function for the packed-slice index.
- Sub-module rr_prioridade: combinational rotating-priority picker.
  - Inputs: req, ponteiro.
  - Outputs: one-hot grant, 3-bit index, any flag.

Test Plan:
- Reset: with req=8'hFF, assert rst_n=0 -> saida=0, seletor=0, saida_valida=0, ack=0. Release rst_n -> ack=8'h01 in the first cycle.
- Rotation: req=8'hFF held, channel i data = 8'h10+i, saida_pronta=1 -> seletor sequence 0,1,...,7,0. saida sequence 8'h10..8'h17. One word per cycle.
- Backpressure: req=8'h04, data 8'hA5, saida_pronta=0 for 5 cycles -> saida=8'hA5 and saida_valida=1 stable for 5 cycles, ack=0 after the first grant. On saida_pronta=1 -> handshake completes.
- Wrap and skip: ponteiro=7 after a grant to channel 6, req=8'h41 -> grant channel 0 (ack=8'h01), then channel 6.
- Reset mid-transfer: saida_valida=1, saida_pronta=0, pulse rst_n low asynchronously between edges -> saida_valida=0 immediately; the next grant after release starts at channel 0.
- ARBITRO_CONTADORES_EN: 70000 grants to channel 3 -> cont_sel=3 gives 16'hFFFF; cont_sel=2 gives 0.
